if_fetch_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 15 +
 rtl/if_id_reg.sv | 41 ++++
 rtl/if_fetch_stage.sv | 114 +++++++++++
 tb/tb_if_fetch_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline front end: fetch FSM states and
// instruction-stream constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int unsigned PC_INCR          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, and anything
// else inserts a bubble.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int bit_size = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                write_en,
    input  logic                load,
    input  logic [bit_size-1:0] next_pc,
    input  logic [bit_size-1:0] fetched_instr,
    output logic [bit_size-1:0] pc,
    output logic [bit_size-1:0] instr,
    output logic                valid
);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pc    <= '0;
            instr <= bit_size'(NOP_INSTR);
            valid <= 1'b0;
        end else if (!write_en) begin
            pc    <= pc;
            instr <= instr;
            valid <= valid;
        end else if (load) begin
            pc    <= next_pc;
            instr <= fetched_instr;
            valid <= 1'b1;
        end else begin
            pc    <= '0;
            instr <= bit_size'(NOP_INSTR);
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: PC register, variable-latency instruction fetch FSM with a
// stall buffer, and the IF/ID register feeding decode.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter int                    bit_size = 32,
    parameter logic [bit_size-1:0]   RESET_PC = bit_size'(DEFAULT_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                PCWrite,
    input  logic                IF_IDWrite,
    input  logic                IF_Flush,
    input  logic                EX_Redirect,
    input  logic [bit_size-1:0] EX_Target,
    output logic                imem_req,
    output logic [bit_size-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [bit_size-1:0] imem_rdata,
    output logic [bit_size-1:0] IF_PC,
    output logic [bit_size-1:0] ID_PC,
    output logic [bit_size-1:0] ID_Instr,
    output logic                ID_Valid
);

    fetch_state_e        state_q, state_d;
    logic [bit_size-1:0] pc_q, pc_d;
    logic [bit_size-1:0] buf_q, buf_d;
    logic                kill_q, kill_d;
    logic [bit_size-1:0] pc_plus;
    logic [bit_size-1:0] instr;
    logic                avail;
    logic                deliver;

    assign pc_plus   = pc_q + bit_size'(PC_INCR);
    assign avail     = ((state_q == WAIT) && imem_ready && !kill_q) || (state_q == HOLD);
    assign instr     = (state_q == HOLD) ? buf_q : imem_rdata;
    assign deliver   = avail && PCWrite && IF_IDWrite && !IF_Flush && !EX_Redirect;
    assign imem_addr = pc_q;
    assign IF_PC     = pc_q;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        buf_d    = buf_q;
        kill_d   = kill_q;
        imem_req = 1'b0;

        unique case (state_q)
            REQ: begin
                imem_req = !EX_Redirect;
                if (!EX_Redirect) state_d = WAIT;
            end
            WAIT: begin
                if (imem_ready) begin
                    // A killed or redirected response is dropped; refetch from the new PC.
                    if (kill_q || EX_Redirect) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else if (deliver) begin
                        state_d = REQ;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = HOLD;
                    end
                end else if (EX_Redirect) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (EX_Redirect || deliver) state_d = REQ;
            end
            default: state_d = REQ;
        endcase

        // Redirect wins over a stalled PC.
        if (EX_Redirect)  pc_d = EX_Target;
        else if (deliver) pc_d = pc_plus;

        if (rst) imem_req = 1'b0;
    end

    // NOTE: the hold buffer is a single register, so it is reset with the rest of the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            kill_q  <= kill_d;
        end
    end

    if_id_reg #(
        .bit_size(bit_size)
    ) u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .flush        (IF_Flush),
        .write_en     (IF_IDWrite),
        .load         (deliver),
        .next_pc      (pc_plus),
        .fetched_instr(instr),
        .pc           (ID_PC),
        .instr        (ID_Instr),
        .valid        (ID_Valid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: an instruction-memory model with
// programmable response gap and a scoreboard of expected IF/ID contents.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        PCWrite;
    logic        IF_IDWrite;
    logic        IF_Flush;
    logic        EX_Redirect;
    logic [31:0] EX_Target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_PC;
    logic [31:0] ID_PC;
    logic [31:0] ID_Instr;
    logic        ID_Valid;

    if_fetch_stage #(
        .bit_size(32),
        .RESET_PC(32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PCWrite    (PCWrite),
        .IF_IDWrite (IF_IDWrite),
        .IF_Flush   (IF_Flush),
        .EX_Redirect(EX_Redirect),
        .EX_Target  (EX_Target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .IF_PC      (IF_PC),
        .ID_PC      (ID_PC),
        .ID_Instr   (ID_Instr),
        .ID_Valid   (ID_Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;

    // Memory model state: one outstanding fetch, answered gap cycles after the request.
    int          gap = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = '0;

    logic        req_seen;
    logic [31:0] req_addr;
    logic        delivered;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        if (a == 32'h10) return 32'h8C22_0000;
        return 32'h0100_0000 | a;
    endfunction

    // One clock: memory drives its response, request is sampled, edge, IF/ID checked.
    task automatic cycle();
        logic was_write;
        exp_t e;
        imem_ready = 1'b0;
        imem_rdata = 32'hBAD0_0000 | $urandom_range(0, 16'hFFFF);
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_ready = 1'b1;
                imem_rdata = instr_of(pend_addr);
                pend       = 1'b0;
            end
        end
        #1;
        req_seen = (imem_req === 1'b1);
        req_addr = imem_addr;
        if (rst) begin
            checks++;
            if (imem_req !== 1'b0) begin
                errors++;
                $display("FAIL req_in_reset: imem_req=%b expected 0", imem_req);
            end
        end
        if (req_seen) begin
            checks++;
            if (pend) begin
                errors++;
                $display("FAIL req_while_outstanding: addr=%h while %h pending", imem_addr, pend_addr);
            end
            pend      = 1'b1;
            cnt       = gap;
            pend_addr = imem_addr;
            exp_q.push_back(exp_t'{pc: imem_addr + 32'd4, instr: instr_of(imem_addr)});
        end
        was_write = IF_IDWrite && !IF_Flush && !rst;
        @(posedge clk);
        #1;
        delivered = 1'b0;
        if (was_write && ID_Valid === 1'b1) begin
            delivered = 1'b1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_delivery: ID_PC=%h ID_Instr=%h with nothing expected", ID_PC, ID_Instr);
            end else begin
                e = exp_q.pop_front();
                if (ID_PC !== e.pc || ID_Instr !== e.instr) begin
                    errors++;
                    $display("FAIL delivery: ID_PC=%h ID_Instr=%h expected %h %h", ID_PC, ID_Instr, e.pc, e.instr);
                end
            end
        end
    endtask

    task automatic expect32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic run_to_req(input logic [31:0] addr);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(req_seen && req_addr == addr) && n < 40);
        checks++;
        if (!(req_seen && req_addr == addr)) begin
            errors++;
            $display("FAIL run_to_req: no request for %h within %0d cycles", addr, n);
        end
    endtask

    task automatic run_to_delivery();
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!delivered && n < 20);
        checks++;
        if (!delivered) begin
            errors++;
            $display("FAIL run_to_delivery: no delivery within %0d cycles", n);
        end
    endtask

    task automatic set_defaults();
        PCWrite     = 1'b1;
        IF_IDWrite  = 1'b1;
        IF_Flush    = 1'b0;
        EX_Redirect = 1'b0;
        EX_Target   = '0;
    endtask

    task automatic do_reset();
        set_defaults();
        pend = 1'b0;
        rst  = 1'b1;
        cycle();
        cycle();
        rst  = 1'b0;
        exp_q.delete();
        pend = 1'b0;
    endtask

    task automatic test_reset();
        gap = 1;
        do_reset();
        rst = 1'b1;
        cycle();
        expect32("reset_if_pc", IF_PC, 32'h0);
        expect32("reset_id_pc", ID_PC, 32'h0);
        expect32("reset_id_instr", ID_Instr, 32'h0);
        expect32("reset_id_valid", {31'b0, ID_Valid}, 32'h0);
        rst = 1'b0;
    endtask

    task automatic test_single_cycle();
        int nreq = 0;
        gap = 1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i % 2 == 0) begin
                nreq++;
                expect32("single_req_addr", req_seen ? req_addr : 32'hFFFF_FFFF, 32'(i * 2));
            end
            expect32("single_id_valid", {31'b0, ID_Valid}, 32'(i % 2));
            if (i % 2 == 1) expect32("single_id_pc", ID_PC, 32'((i + 1) * 2));
        end
    endtask

    task automatic test_latency();
        int nreq = 0;
        int ndel = 0;
        gap = 2;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (req_seen) nreq++;
            if (delivered) ndel++;
            expect32("lat_req", {31'b0, req_seen}, (i % 3 == 0) ? 32'd1 : 32'd0);
            expect32("lat_id_valid", {31'b0, ID_Valid}, (i % 3 == 2) ? 32'd1 : 32'd0);
        end
        expect32("lat_req_count", 32'(nreq), 32'd4);
        expect32("lat_delivery_count", 32'(ndel), 32'd4);
    endtask

    task automatic test_stall();
        logic [31:0] held_pc;
        logic [31:0] held_instr;
        logic        held_valid;
        gap = 1;
        do_reset();
        run_to_req(32'h10);
        held_pc    = ID_PC;
        held_instr = ID_Instr;
        held_valid = ID_Valid;
        PCWrite    = 1'b0;
        IF_IDWrite = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            expect32("stall_req", {31'b0, req_seen}, 32'd0);
            expect32("stall_if_pc", IF_PC, 32'h10);
            expect32("stall_id_pc", ID_PC, held_pc);
            expect32("stall_id_instr", ID_Instr, held_instr);
            expect32("stall_id_valid", {31'b0, ID_Valid}, {31'b0, held_valid});
        end
        PCWrite    = 1'b1;
        IF_IDWrite = 1'b1;
        cycle();
        expect32("stall_release_valid", {31'b0, delivered}, 32'd1);
        expect32("stall_release_instr", ID_Instr, 32'h8C22_0000);
        expect32("stall_release_pc", ID_PC, 32'h14);
        cycle();
        expect32("stall_next_addr", req_seen ? req_addr : 32'hFFFF_FFFF, 32'h14);
    endtask

    task automatic test_redirect();
        gap = 3;
        do_reset();
        run_to_req(32'h8);
        EX_Redirect = 1'b1;
        EX_Target   = 32'h40;
        cycle();
        EX_Redirect = 1'b0;
        exp_q.delete();
        expect32("redir_if_pc", IF_PC, 32'h40);
        cycle();
        expect32("redir_no_req_wait", {31'b0, req_seen}, 32'd0);
        cycle();
        expect32("redir_discard_valid", {31'b0, ID_Valid}, 32'd0);
        expect32("redir_no_req_resp", {31'b0, req_seen}, 32'd0);
        cycle();
        expect32("redir_next_addr", req_seen ? req_addr : 32'hFFFF_FFFF, 32'h40);
        run_to_delivery();
        expect32("redir_id_pc", ID_PC, 32'h44);
    endtask

    task automatic test_flush();
        gap = 1;
        do_reset();
        cycle();
        cycle();
        expect32("flush_first_valid", {31'b0, delivered}, 32'd1);
        PCWrite    = 1'b0;
        IF_IDWrite = 1'b0;
        cycle();
        expect32("flush_req_addr", req_seen ? req_addr : 32'hFFFF_FFFF, 32'h4);
        expect32("flush_hold_pc", ID_PC, 32'h4);
        expect32("flush_hold_valid", {31'b0, ID_Valid}, 32'd1);
        IF_Flush    = 1'b1;
        EX_Redirect = 1'b1;
        EX_Target   = 32'h80;
        cycle();
        exp_q.delete();
        expect32("flush_bubble_valid", {31'b0, ID_Valid}, 32'd0);
        expect32("flush_bubble_instr", ID_Instr, 32'h0);
        expect32("flush_bubble_pc", ID_PC, 32'h0);
        expect32("flush_redirect_pc", IF_PC, 32'h80);
        set_defaults();
        cycle();
        expect32("flush_next_addr", req_seen ? req_addr : 32'hFFFF_FFFF, 32'h80);
        run_to_delivery();
        expect32("flush_id_pc", ID_PC, 32'h84);
    endtask

    task automatic test_reset_mid_wait();
        gap = 3;
        do_reset();
        run_to_req(32'h4);
        rst = 1'b1;
        cycle();
        expect32("midrst_if_pc", IF_PC, 32'h0);
        expect32("midrst_id_valid", {31'b0, ID_Valid}, 32'd0);
        cycle();
        rst = 1'b0;
        exp_q.delete();
        cycle();
        expect32("midrst_first_addr", req_seen ? req_addr : 32'hFFFF_FFFF, 32'h0);
        expect32("midrst_stray_valid", {31'b0, ID_Valid}, 32'd0);
        run_to_delivery();
        expect32("midrst_id_instr", ID_Instr, instr_of(32'h0));
        expect32("midrst_id_pc", ID_PC, 32'h4);
    endtask

    initial begin
        rst        = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = '0;
        set_defaults();
        @(posedge clk);
        #1;
        test_reset();
        test_single_cycle();
        test_latency();
        test_stall();
        test_redirect();
        test_flush();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
